branch_predictor: RTL and testbench

//   Parametrised dynamic branch predictor with branch target buffer (BTB) for the 5-stage RV32I pipeline.

---
 rtl/branch_predictor.sv | 78 +++++++
 tb/tb_branch_predictor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters, trained from E stage.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_tgt,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] WEAK_N = WEAK_T - CNT_W'(1);
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;
    logic [CNT_W-1:0] u_cnt;
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{PCF, upd_pc};
    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    assign u_cnt = cnt_q[u_idx];
    // lookup reads pre-update table contents; no bypass from the training port
    always_comb begin
        pred_taken  = f_hit && cnt_q[f_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[f_idx] : PCF + 32'd4;
        mispredict  = upd_en && (upd_taken != upd_pred_taken ||
                      (upd_taken && upd_pred_taken && upd_target != upd_pred_tgt));
        redirect_pc = upd_en && upd_taken ? upd_target : upd_pc + 32'd4;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= WEAK_N;
            end
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_en && u_hit)
                cnt_q[u_idx] <= upd_taken ? (u_cnt == CNT_MAX ? u_cnt : u_cnt + CNT_W'(1))
                                          : (u_cnt == '0 ? u_cnt : u_cnt - CNT_W'(1));
            else if (upd_en && upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                cnt_q[u_idx]   <= WEAK_T;
            end
            stat_branches <= stat_branches + 32'(upd_en && !(&stat_branches));
            stat_mispred  <= stat_mispred + 32'(mispredict && !(&stat_mispred));
        end
    end
    // every taken update writes the target, whether it hits or allocates
    always_ff @(posedge clk) begin
        if (!rst && upd_en && upd_taken)
            tgt_q[u_idx] <= upd_target;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, mispredict and statistics.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_tgt;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .PCF(PCF), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_tgt(upd_pred_tgt),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
        upd_pred_taken = pt; upd_pred_tgt = ptgt;
    endtask

    task automatic cyc;
        @(negedge clk);
        upd_en = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; PCF = 32'h100;
        upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_tgt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pt", 32'(pred_taken), 0);
        chk("rst_ptgt", pred_target, 32'h104);
        chk("rst_sb", stat_branches, 0);
        chk("rst_sm", stat_mispred, 0);
        upd(32'h100, 1, 32'h80, 0, 32'h104);
        #1;
        chk("cold_mp", 32'(mispredict), 1);
        chk("cold_redir", redirect_pc, 32'h80);
        chk("cold_same_cycle_pt", 32'(pred_taken), 0);
        cyc;
        chk("trained_pt", 32'(pred_taken), 1);
        chk("trained_ptgt", pred_target, 32'h80);
        for (int i = 0; i < 4; i++) begin
            upd(32'h100, 1, 32'h80, 1, 32'h80);
            #1;
            chk("sat_mp", 32'(mispredict), 0);
            cyc;
        end
        chk("sat_pt", 32'(pred_taken), 1);
        upd(32'h100, 0, 32'h80, 1, 32'h80);
        #1;
        chk("nt1_mp", 32'(mispredict), 1);
        chk("nt1_redir", redirect_pc, 32'h104);
        cyc;
        chk("hyst_pt", 32'(pred_taken), 1);
        upd(32'h100, 0, 32'h80, 1, 32'h80);
        cyc;
        chk("nt2_pt", 32'(pred_taken), 0);
        chk("nt2_ptgt", pred_target, 32'h104);
        for (int i = 0; i < 5; i++) begin
            upd(32'h100, 0, 32'h80, 0, 32'h104);
            #1;
            chk("floor_mp", 32'(mispredict), 0);
            cyc;
            chk("floor_pt", 32'(pred_taken), 0);
        end
        chk("stat_sb12", stat_branches, 12);
        chk("stat_sm3", stat_mispred, 3);
        upd(32'h100, 1, 32'h80, 0, 32'h104);
        cyc;
        chk("cnt1_pt", 32'(pred_taken), 0);
        upd(32'h100, 1, 32'h80, 0, 32'h104);
        cyc;
        chk("cnt2_pt", 32'(pred_taken), 1);
        upd(32'h100, 1, 32'h90, 1, 32'h80);
        #1;
        chk("tchg_mp", 32'(mispredict), 1);
        chk("tchg_redir", redirect_pc, 32'h90);
        cyc;
        chk("tchg_ptgt", pred_target, 32'h90);
        PCF = 32'h200;
        #1;
        chk("alias_pt", 32'(pred_taken), 0);
        chk("alias_ptgt", pred_target, 32'h204);
        PCF = 32'h100;
        upd(32'h100, 1, 32'hA0, 1, 32'h90);
        #1;
        chk("bypass_ptgt", pred_target, 32'h90);
        cyc;
        chk("after_ptgt", pred_target, 32'hA0);
        PCF = 32'h200;
        upd(32'h200, 0, 32'h0, 0, 32'h204);
        #1;
        chk("missnt_mp", 32'(mispredict), 0);
        chk("missnt_redir", redirect_pc, 32'h204);
        cyc;
        chk("missnt_pt", 32'(pred_taken), 0);
        chk("stat_sb17", stat_branches, 17);
        chk("stat_sm7", stat_mispred, 7);
        upd_pc = 32'h300; upd_taken = 1; upd_target = 32'h10; upd_pred_taken = 0;
        #1;
        chk("idle_mp", 32'(mispredict), 0);
        chk("idle_redir", redirect_pc, 32'h304);
        PCF = 32'hFFFF_FFFC;
        #1;
        chk("wrap_ptgt", pred_target, 32'h0);
        rst = 1'b1;
        upd(32'h300, 1, 32'h10, 0, 32'h304);
        @(negedge clk);
        rst = 1'b0; upd_en = 1'b0; PCF = 32'h100;
        #1;
        chk("rst2_pt100", 32'(pred_taken), 0);
        chk("rst2_sb", stat_branches, 0);
        chk("rst2_sm", stat_mispred, 0);
        PCF = 32'h300;
        #1;
        chk("rst2_pt300", 32'(pred_taken), 0);
        for (int i = 0; i < 10; i++) begin
            upd(32'h400, 1, 32'h40, !(i == 0 || i == 3 || i == 7), i == 0 ? 32'h404 : 32'h40);
            cyc;
        end
        chk("stat10_sb", stat_branches, 10);
        chk("stat10_sm", stat_mispred, 3);
        dut.stat_branches = 32'hFFFF_FFFE;
        dut.stat_mispred  = 32'hFFFF_FFFE;
        upd(32'h400, 1, 32'h40, 0, 32'h404);
        cyc;
        chk("max_sb", stat_branches, 32'hFFFF_FFFF);
        chk("max_sm", stat_mispred, 32'hFFFF_FFFF);
        upd(32'h400, 1, 32'h40, 0, 32'h404);
        cyc;
        chk("hold_sb", stat_branches, 32'hFFFF_FFFF);
        chk("hold_sm", stat_mispred, 32'hFFFF_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
